// File: rtl/cordic_pkg.sv
// Shared types and constants for the cordic request scheduler.
package cordic_pkg;

    localparam int ANGLE_W = 16;

    // Angles the engine resolves without running its rotation loop
    localparam logic [ANGLE_W-1:0] ANGLE_0  = 16'h0000;
    localparam logic [ANGLE_W-1:0] ANGLE_45 = 16'h4000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Combinational requester arbiter: round-robin from a pointer, or fixed
// lowest-index priority when CORDIC_SCHED_PRIO_EN is defined.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
`ifndef CORDIC_SCHED_PRIO_EN
    input  logic [IDX_W-1:0] i_ptr,
`endif
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic [N_REQ-1:0] w_grant;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_j;
    logic             w_found;
    int               j;

    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef CORDIC_SCHED_PRIO_EN
            j = k;
`else
            j = (int'(i_ptr) + k) % N_REQ;
`endif
            w_j = IDX_W'(j);
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                w_grant[w_j] = 1'b1;
                w_idx        = w_j;
            end
        end
    end

    assign o_grant = w_grant;
    assign o_idx   = w_idx;

endmodule

// File: rtl/cordic_sched.sv
// Shares one cordic engine between N_REQ angle requesters, one job at a time.
// Define CORDIC_SCHED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [ANGLE_W*N_REQ-1:0]  req_angle,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      rsp_valid,
    output logic [IDX_W-1:0]          rsp_id,
    output logic signed [ANGLE_W-1:0] rsp_cos,
    output logic signed [ANGLE_W-1:0] rsp_sin,
    output logic                      busy,
    output logic                      cor_start,
    output logic [ANGLE_W-1:0]        cor_angle,
    input  logic signed [ANGLE_W-1:0] cor_cos,
    input  logic signed [ANGLE_W-1:0] cor_sin,
    input  logic                      cor_valid,
    input  logic                      cor_recived
);

    sched_state_t              r_state;
    logic [N_REQ-1:0]          r_ready;
    logic                      r_rsp_valid;
    logic [IDX_W-1:0]          r_rsp_id;
    logic signed [ANGLE_W-1:0] r_cos;
    logic signed [ANGLE_W-1:0] r_sin;
    logic                      r_busy;
    logic                      r_start;
    logic [ANGLE_W-1:0]        r_angle;
    logic [IDX_W-1:0]          r_id;
    logic [15:0]               r_recv_cnt;

    logic [N_REQ-1:0]          w_grant;
    logic [IDX_W-1:0]          w_idx;
    logic [ANGLE_W-1:0]        w_angle;

`ifndef CORDIC_SCHED_PRIO_EN
    logic [IDX_W-1:0]          r_ptr;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (req_valid),
`ifndef CORDIC_SCHED_PRIO_EN
        .i_ptr   (r_ptr),
`endif
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_angle = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_angle = req_angle[ANGLE_W*i +: ANGLE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_cos       <= '0;
            r_sin       <= '0;
            r_busy      <= 1'b0;
            r_start     <= 1'b0;
            r_angle     <= '0;
            r_id        <= '0;
            r_recv_cnt  <= '0;
`ifndef CORDIC_SCHED_PRIO_EN
            r_ptr       <= '0;
`endif
        end else begin
            r_ready     <= '0;
            r_rsp_valid <= 1'b0;
            if (cor_recived) r_recv_cnt <= r_recv_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        r_ready <= w_grant;
                        r_angle <= w_angle;
                        r_id    <= w_idx;
                        r_busy  <= 1'b1;
                        r_start <= 1'b1;
                        r_state <= ST_ISSUE;
`ifndef CORDIC_SCHED_PRIO_EN
                        if (w_idx == IDX_W'(N_REQ-1)) r_ptr <= '0;
                        else                          r_ptr <= w_idx + 1'b1;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (cor_valid) begin
                        r_cos       <= cor_cos;
                        r_sin       <= cor_sin;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_start     <= 1'b0;
                        r_state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // Engine must drop valid (back in its IDLE) before a new start
                    if (!cor_valid) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_cos   = r_cos;
    assign rsp_sin   = r_sin;
    assign busy      = r_busy;
    assign cor_start = r_start;
    assign cor_angle = r_angle;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: behavioural cordic engine stand-in plus a grant-order
// and result scoreboard; honours CORDIC_SCHED_PRIO_EN when defined.
module tb_cordic_sched;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [16*N-1:0]    req_angle = '0;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic signed [15:0] rsp_cos, rsp_sin;
    logic               busy, cor_start;
    logic [15:0]        cor_angle;
    logic signed [15:0] cor_cos, cor_sin;
    logic               cor_valid, cor_recived;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    always #5 clk = ~clk;

    cordic_sched #(.N_REQ(N), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .busy(busy), .cor_start(cor_start), .cor_angle(cor_angle),
        .cor_cos(cor_cos), .cor_sin(cor_sin), .cor_valid(cor_valid), .cor_recived(cor_recived)
    );

    // Stand-in engine results: known fast-path values, arbitrary mixes otherwise
    function automatic logic [15:0] ref_cos(input logic [15:0] a);
        if (a == 16'h0000) return 16'h8000;
        if (a == 16'h4000) return 16'h5A82;
        return (a * 16'd3) ^ 16'h5555;
    endfunction

    function automatic logic [15:0] ref_sin(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0000;
        if (a == 16'h4000) return 16'h5A82;
        return ~a + 16'd7;
    endfunction

    // Engine: start seen in idle -> busy for a latency -> valid held until start
    // drops, one more cycle of valid, then back to idle.
    int          e_st;
    int          e_cnt;
    logic [15:0] e_ang;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_st <= 0; e_cnt <= 0; e_ang <= '0;
            cor_valid <= 1'b0; cor_recived <= 1'b0; cor_cos <= '0; cor_sin <= '0;
        end else begin
            cor_recived <= 1'b0;
            case (e_st)
                0: if (cor_start) begin
                    e_st <= 1; e_ang <= cor_angle; cor_recived <= 1'b1;
                    e_cnt <= (cor_angle == 16'h0000 || cor_angle == 16'h4000) ? 2 : 33;
                end
                1: if (e_cnt == 0) begin
                    e_st <= 2; cor_valid <= 1'b1;
                    cor_cos <= ref_cos(e_ang); cor_sin <= ref_sin(e_ang);
                end else e_cnt <= e_cnt - 1;
                2: if (!cor_start) e_st <= 3;
                default: begin cor_valid <= 1'b0; e_st <= 0; end
            endcase
        end
    end

    // Reference arbitration: first requester at or after the pointer, wrapping
    function automatic int model_pick(input logic [N-1:0] v, input int ptr);
        int idx;
`ifdef CORDIC_SCHED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            idx = i;
            if (v[idx[1:0]]) return idx;
        end
`else
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (v[idx[1:0]]) return idx;
        end
`endif
        return -1;
    endfunction

    // Protocol monitor
    logic m_prev_start = 1'b0, m_prev_rsp = 1'b0;
    logic [N-1:0] m_prev_ready = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cor_start && !m_prev_start) begin
                n_checks++;
                if (cor_valid !== 1'b0) begin
                    n_fail++; $display("FAIL start_while_valid: cor_valid=%b required 0", cor_valid);
                end
            end
            if (|req_ready || rsp_valid) begin
                n_checks++;
                if ((|req_ready && rsp_valid) || (|req_ready && |m_prev_ready) ||
                    (rsp_valid && m_prev_rsp) || $countones(req_ready) > 1) begin
                    n_fail++;
                    $display("FAIL pulse_rules: ready=%b rsp_valid=%b prev_ready=%b prev_rsp=%b required single isolated pulses",
                             req_ready, rsp_valid, m_prev_ready, m_prev_rsp);
                end
            end
        end
        m_prev_start = cor_start;
        m_prev_ready = req_ready;
        m_prev_rsp   = rsp_valid;
    end

    task automatic wait_ready(output int g, output bit to);
        g = -1; to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (|req_ready) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                to = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output bit to);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rsp_valid) begin to = 1'b0; return; end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d required 0", rsp_id); end
        n_checks++; if (rsp_cos !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_cos: got %h required 0", rsp_cos); end
        n_checks++; if (rsp_sin !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_sin: got %h required 0", rsp_sin); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (cor_start !== 1'b0) begin n_fail++; $display("FAIL reset_cor_start: got %b required 0", cor_start); end
        n_checks++; if (cor_angle !== 16'h0) begin n_fail++; $display("FAIL reset_cor_angle: got %h required 0", cor_angle); end
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_fast_path();
        int g, eg; bit to;
        req_angle[16*1 +: 16] = 16'h4000;
        req_valid = 4'b0010;
        eg = model_pick(req_valid, m_ptr);
        wait_ready(g, to);
        n_checks++;
        if (to || req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL fast_ready: got %b required 0010", req_ready); req_valid = '0; return;
        end
        req_valid = '0;
        m_ptr = (eg + 1) % N;
        n_checks++; if (cor_angle !== 16'h4000) begin n_fail++; $display("FAIL fast_cor_angle: got %h required 4000", cor_angle); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fast_busy: got %b required 1", busy); end
        wait_rsp(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL fast_rsp_timeout: got no rsp_valid required one"); return; end
        n_checks++; if (rsp_id !== 2'(eg)) begin n_fail++; $display("FAIL fast_rsp_id: got %0d required %0d", rsp_id, eg); end
        n_checks++; if (rsp_cos !== 16'h5A82) begin n_fail++; $display("FAIL fast_rsp_cos: got %h required 5a82", rsp_cos); end
        n_checks++; if (rsp_sin !== 16'h5A82) begin n_fail++; $display("FAIL fast_rsp_sin: got %h required 5a82", rsp_sin); end
    endtask

    task automatic test_zero_angle();
        int g, eg; bit to;
        req_angle[0 +: 16] = 16'h0000;
        req_valid = 4'b0001;
        eg = model_pick(req_valid, m_ptr);
        wait_ready(g, to);
        n_checks++;
        if (to || g != eg) begin
            n_fail++; $display("FAIL zero_grant: got %0d required %0d", g, eg); req_valid = '0; return;
        end
        req_valid = '0;
        m_ptr = (eg + 1) % N;
        wait_rsp(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL zero_rsp_timeout: got no rsp_valid required one"); return; end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL zero_rsp_id: got %0d required 0", rsp_id); end
        n_checks++; if (rsp_cos !== 16'h8000) begin n_fail++; $display("FAIL zero_rsp_cos: got %h required 8000", rsp_cos); end
        n_checks++; if (rsp_sin !== 16'h0000) begin n_fail++; $display("FAIL zero_rsp_sin: got %h required 0000", rsp_sin); end
    endtask

    task automatic test_round_robin();
        logic [15:0] ang [N];
        logic [N-1:0] held, oh;
        int g, eg; bit to;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < N; i++) begin
                ang[i] = {2'(i), 14'($urandom)} | 16'h0100;
                req_angle[16*i +: 16] = ang[i];
            end
            held = '1;
            req_valid = held;
            for (int j = 0; j < N; j++) begin
                eg = model_pick(held, m_ptr);
                oh = '0; oh[eg[1:0]] = 1'b1;
                wait_ready(g, to);
                n_checks++;
                if (to || req_ready !== oh) begin
                    n_fail++; $display("FAIL rr_grant: got %b required %b", req_ready, oh);
                    req_valid = '0; return;
                end
                n_checks++;
                if (cor_angle !== ang[eg]) begin n_fail++; $display("FAIL rr_cor_angle: got %h required %h", cor_angle, ang[eg]); end
                held[eg[1:0]] = 1'b0;
                req_valid = held;
                m_ptr = (eg + 1) % N;
                wait_rsp(to);
                n_checks++;
                if (to) begin n_fail++; $display("FAIL rr_rsp_timeout: got no rsp_valid required one"); return; end
                n_checks++; if (rsp_id !== 2'(eg)) begin n_fail++; $display("FAIL rr_rsp_id: got %0d required %0d", rsp_id, eg); end
                n_checks++; if (rsp_cos !== ref_cos(ang[eg])) begin n_fail++; $display("FAIL rr_rsp_cos: got %h required %h", rsp_cos, ref_cos(ang[eg])); end
                n_checks++; if (rsp_sin !== ref_sin(ang[eg])) begin n_fail++; $display("FAIL rr_rsp_sin: got %h required %h", rsp_sin, ref_sin(ang[eg])); end
            end
        end
    endtask

    task automatic test_starvation();
        logic [N-1:0] held, oh;
        int g, eg; bit to, got3, exp3;
        got3 = 1'b0;
        req_angle[0 +: 16]    = 16'h0000;
        req_angle[16*3 +: 16] = 16'h4000;
        held = 4'b1001;
        req_valid = held;
        for (int j = 0; j < 4; j++) begin
            eg = model_pick(held, m_ptr);
            oh = '0; oh[eg[1:0]] = 1'b1;
            wait_ready(g, to);
            n_checks++;
            if (to || req_ready !== oh) begin
                n_fail++; $display("FAIL starve_grant: got %b required %b", req_ready, oh);
                req_valid = '0; return;
            end
            if (g == 3) begin got3 = 1'b1; held[3] = 1'b0; end
            req_valid = held;
            m_ptr = (eg + 1) % N;
            wait_rsp(to);
            n_checks++;
            if (to || rsp_id !== 2'(eg)) begin
                n_fail++; $display("FAIL starve_rsp_id: got %0d required %0d", rsp_id, eg);
                req_valid = '0; return;
            end
        end
`ifdef CORDIC_SCHED_PRIO_EN
        exp3 = 1'b0;
`else
        exp3 = 1'b1;
`endif
        n_checks++;
        if (got3 !== exp3) begin n_fail++; $display("FAIL starve_req3: granted=%b required %b", got3, exp3); end
        req_valid = '0;
        wait_ready(g, to);
        if (!to) begin
            m_ptr = (g + 1) % N;
            wait_rsp(to);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_release_window();
        logic [N-1:0] oh;
        int g, eg, c; bit to; logic prev_cv, prev_busy;
        req_angle[16*2 +: 16] = 16'h0000;
        req_valid = 4'b0100;
        wait_ready(g, to);
        req_valid = '0;
        if (!to) m_ptr = (g + 1) % N;
        wait_rsp(to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rel_first_rsp: got no rsp_valid required one"); return; end
        req_angle[16*1 +: 16] = 16'h2345;
        req_valid = 4'b0010;
        eg = model_pick(req_valid, m_ptr);
        oh = '0; oh[eg[1:0]] = 1'b1;
        prev_cv = cor_valid; prev_busy = busy;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (|req_ready) break;
            prev_cv = cor_valid; prev_busy = busy;
        end
        n_checks++;
        if (req_ready !== oh) begin
            n_fail++; $display("FAIL rel_grant: got %b required %b", req_ready, oh); req_valid = '0; return;
        end
        req_valid = '0;
        m_ptr = (eg + 1) % N;
        n_checks++; if (prev_cv !== 1'b0) begin n_fail++; $display("FAIL rel_valid_before_grant: got %b required 0", prev_cv); end
        n_checks++; if (prev_busy !== 1'b0) begin n_fail++; $display("FAIL rel_idle_before_grant: busy=%b required 0", prev_busy); end
        n_checks++; if (c < 2) begin n_fail++; $display("FAIL rel_gap: got %0d cycles required >= 2", c); end
        wait_rsp(to);
        n_checks++;
        if (to || rsp_cos !== ref_cos(16'h2345)) begin
            n_fail++; $display("FAIL rel_rsp_cos: got %h required %h", rsp_cos, ref_cos(16'h2345));
        end
    endtask

    task automatic test_reset_mid_job();
        int g, eg; bit to, seen;
        req_angle[16*2 +: 16] = 16'h1234;
        req_valid = 4'b0100;
        wait_ready(g, to);
        req_valid = '0;
        n_checks++;
        if (to) begin n_fail++; $display("FAIL mid_first_grant: got none required one"); return; end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_cos !== 16'h0 ||
            rsp_sin !== 16'h0 || busy !== 1'b0 || cor_start !== 1'b0 || cor_angle !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_async_clear: ready=%b rv=%b id=%0d cos=%h sin=%h busy=%b start=%b ang=%h required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_cos, rsp_sin, busy, cor_start, cor_angle);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL mid_dropped_job: rsp_valid=1 required none"); end
        req_angle[16*3 +: 16] = 16'h4000;
        req_valid = 4'b1000;
        eg = model_pick(req_valid, m_ptr);
        wait_ready(g, to);
        req_valid = '0;
        n_checks++;
        if (to || g != eg) begin n_fail++; $display("FAIL mid_regrant: got %0d required %0d", g, eg); return; end
        wait_rsp(to);
        n_checks++;
        if (to || rsp_id !== 2'd3 || rsp_cos !== 16'h5A82) begin
            n_fail++; $display("FAIL mid_after_reset: id=%0d cos=%h required 3 and 5a82", rsp_id, rsp_cos);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fast_path();
        test_zero_angle();
        test_round_robin();
        test_starvation();
        test_release_window();
        test_reset_mid_job();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
